cascade_counter: RTL and testbench

Parametrised multi-stage modular counter. It chains NUM_STAGES digit stages, each with a run-time programmable modulus, and adds up/down counting, synchronous clear and parallel load. It provides per-stage carry/borrow outputs and a terminal-count flag. It is used for timebases, BCD/time-of-day counters and multi-dimensional address walkers, and replaces ad-hoc cascades of fixed-modulus counters.

---
 rtl/cascade_counter_pkg.sv | 14 +
 rtl/cascade_counter_stage.sv | 50 +++++
 rtl/cascade_counter.sv | 51 +++++
 tb/tb_cascade_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cascade_counter_pkg.sv
// Shared types and default sizing for the cascaded modular counter.
package cascade_counter_pkg;

  localparam int DEF_NUM_STAGES = 3;
  localparam int DEF_W          = 8;

  typedef logic [DEF_W-1:0] count_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/cascade_counter_stage.sv
// One digit of the cascade: a W-bit counter with programmable modulus (0 means 2^W).
module cascade_counter_stage
  import cascade_counter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  dir_e         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] cnt,
  output logic         at_end
);

  logic [W-1:0] term;
  logic [W-1:0] cnt_next;

  // Wraps naturally, so a modulus of 0 yields the full all-ones range.
  assign term = modulus - W'(1);

  always_comb begin
    if (dir == DIR_DOWN) at_end = (cnt == '0);
    else                 at_end = (cnt >= term);
  end

  // Counts above term snap back in a single step in either direction.
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = load_val;
    end else if (step) begin
      if (dir == DIR_UP)    cnt_next = at_end ? '0 : cnt + W'(1);
      else if (cnt == '0)   cnt_next = term;
      else if (cnt > term)  cnt_next = term;
      else                  cnt_next = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

endmodule

// File: rtl/cascade_counter.sv
// Multi-stage modular counter: stage 0 is least significant, carries ripple combinationally.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int W          = DEF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    clr,
  input  logic                    load,
  input  logic [NUM_STAGES*W-1:0] load_val,
  input  logic [NUM_STAGES*W-1:0] modulus,
  output logic [NUM_STAGES*W-1:0] cnt,
  output logic [NUM_STAGES-1:0]   co,
  output logic                    tc
);

  logic [NUM_STAGES-1:0] step;
  logic [NUM_STAGES-1:0] at_end;

  // at_end depends only on registered counts, so this chain has no loop.
  always_comb begin
    step    = '0;
    step[0] = en;
    for (int k = 1; k < NUM_STAGES; k++) begin
      step[k] = step[k-1] & at_end[k-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    cascade_counter_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step[k]),
      .dir      (dir_e'(dir)),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[k*W +: W]),
      .modulus  (modulus[k*W +: W]),
      .cnt      (cnt[k*W +: W]),
      .at_end   (at_end[k])
    );
  end

  assign co = step & at_end;
  assign tc = co[NUM_STAGES-1];

endmodule

// File: tb/tb_cascade_counter.sv
// Directed scoreboard bench for cascade_counter: an 8-bit instance and a 4-bit instance for edge moduli.
module tb_cascade_counter;
  import cascade_counter_pkg::*;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int W4 = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [N*W-1:0] load_val = '0, modulus = '0, cnt;
  logic [N-1:0]   co;
  logic           tc;

  logic            en4 = 1'b0, dir4 = 1'b0, clr4 = 1'b0, load4 = 1'b0;
  logic [N*W4-1:0] load_val4 = '0, modulus4 = '0, cnt4;
  logic [N-1:0]    co4;
  logic            tc4;

  typedef struct {
    string          tag;
    logic [N-1:0]   co;
    logic [N*W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [N*W-1:0] M_TOD = {8'd24, 8'd60, 8'd60};
  localparam logic [N*W-1:0] M_TEN = {8'd10, 8'd10, 8'd10};

  always #5 clk = ~clk;

  cascade_counter #(.NUM_STAGES(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .modulus(modulus), .cnt(cnt), .co(co), .tc(tc)
  );

  cascade_counter #(.NUM_STAGES(N), .W(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .dir(dir4), .clr(clr4), .load(load4),
    .load_val(load_val4), .modulus(modulus4), .cnt(cnt4), .co(co4), .tc(tc4)
  );

  task automatic compare(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Pops the oldest expectation once the edge it describes has happened.
  task automatic check_output(input logic wide);
    exp_t item;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("[TB] FAIL scoreboard_empty: observed 0 expected 1");
    end else begin
      item = sb.pop_front();
      if (wide) compare({item.tag, "_cnt"}, 24'(cnt), 24'(item.cnt));
      else      compare({item.tag, "_cnt"}, 24'(cnt4), 24'(item.cnt));
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic e, input logic d, input logic c,
                                input logic l, input logic [N*W-1:0] lv, input logic [N*W-1:0] md,
                                input logic [N-1:0] exp_co, input logic [N*W-1:0] exp_cnt);
    @(negedge clk);
    en = e; dir = d; clr = c; load = l; load_val = lv; modulus = md;
    sb.push_back('{tag, exp_co, exp_cnt});
    #1;
    compare({tag, "_co"}, 24'(co), 24'(sb[0].co));
    compare({tag, "_tc"}, 24'(tc), 24'(sb[0].co[N-1]));
    check_output(1'b1);
  endtask

  task automatic apply_stimulus4(input string tag, input logic [N-1:0] exp_co,
                                 input logic [N*W4-1:0] exp_cnt);
    @(negedge clk);
    en4 = 1'b1;
    sb.push_back('{tag, exp_co, 24'(exp_cnt)});
    #1;
    compare({tag, "_co"}, 24'(co4), 24'(sb[0].co));
    compare({tag, "_tc"}, 24'(tc4), 24'(sb[0].co[N-1]));
    check_output(1'b0);
  endtask

  task automatic run_edges(input int n);
    en = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modulus  = M_TOD;
    modulus4 = {4'd3, 4'd1, 4'd0};
    #12;
    compare("rst_cnt", 24'(cnt), 24'd0);
    compare("rst_co", 24'(co), 24'd0);
    compare("rst_tc", 24'(tc), 24'd0);
    compare("rst_cnt4", 24'(cnt4), 24'd0);

    // Time-of-day walk with en high from reset release, fast-forwarded by load near midnight.
    @(negedge clk);
    rst_n = 1'b1;
    run_edges(58);
    apply_stimulus("t1_sec59", 1, 0, 0, 0, '0, M_TOD, 3'b000, {8'd0, 8'd0, 8'd59});
    apply_stimulus("t1_min1",  1, 0, 0, 0, '0, M_TOD, 3'b001, {8'd0, 8'd1, 8'd0});
    run_edges(3538);
    apply_stimulus("t1_3599",  1, 0, 0, 0, '0, M_TOD, 3'b000, {8'd0, 8'd59, 8'd59});
    apply_stimulus("t1_hour1", 1, 0, 0, 0, '0, M_TOD, 3'b011, {8'd1, 8'd0, 8'd0});
    apply_stimulus("t1_ldend", 1, 0, 0, 1, {8'd23, 8'd59, 8'd58}, M_TOD, 3'b000, {8'd23, 8'd59, 8'd58});
    apply_stimulus("t1_term",  1, 0, 0, 0, '0, M_TOD, 3'b000, {8'd23, 8'd59, 8'd59});
    apply_stimulus("t1_wrap",  1, 0, 0, 0, '0, M_TOD, 3'b111, {8'd0, 8'd0, 8'd0});

    // Down counting from all zeros borrows through every stage.
    apply_stimulus("t2_load",  0, 1, 0, 1, '0, M_TEN, 3'b000, {8'd0, 8'd0, 8'd0});
    apply_stimulus("t2_999",   1, 1, 0, 0, '0, M_TEN, 3'b111, {8'd9, 8'd9, 8'd9});
    apply_stimulus("t2_998",   1, 1, 0, 0, '0, M_TEN, 3'b000, {8'd9, 8'd9, 8'd8});

    // clr beats load beats en.
    apply_stimulus("t3_clr",   1, 0, 1, 1, {8'd1, 8'd2, 8'd3}, M_TEN, 3'b000, '0);
    apply_stimulus("t3_load",  1, 0, 0, 1, {8'd5, 8'd4, 8'd3}, M_TEN, 3'b000, {8'd5, 8'd4, 8'd3});
    apply_stimulus("t3_inc",   1, 0, 0, 0, '0, M_TEN, 3'b000, {8'd5, 8'd4, 8'd4});

    // Out-of-range count after a modulus change resyncs in one step.
    apply_stimulus("t4_ld50",  0, 0, 0, 1, {8'd0, 8'd0, 8'd50}, {8'd10, 8'd10, 8'd60}, 3'b000, {8'd0, 8'd0, 8'd50});
    apply_stimulus("t4_upfix", 1, 0, 0, 0, '0, M_TEN, 3'b001, {8'd0, 8'd1, 8'd0});
    apply_stimulus("t4_ld50d", 0, 0, 0, 1, {8'd0, 8'd0, 8'd50}, M_TEN, 3'b000, {8'd0, 8'd0, 8'd50});
    apply_stimulus("t4_dnfix", 1, 1, 0, 0, '0, M_TEN, 3'b000, {8'd0, 8'd0, 8'd9});

    // Asynchronous reset in the middle of a count, away from any clock edge.
    apply_stimulus("t6_pre1",  1, 0, 0, 0, '0, M_TEN, 3'b001, {8'd0, 8'd1, 8'd0});
    apply_stimulus("t6_pre2",  1, 0, 0, 0, '0, M_TEN, 3'b000, {8'd0, 8'd1, 8'd1});
    @(negedge clk);
    #2;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    compare("t6_async_cnt", 24'(cnt), 24'd0);
    compare("t6_async_co", 24'(co), 24'd0);
    compare("t6_async_tc", 24'(tc), 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("t6_resume", 1, 0, 0, 0, '0, M_TEN, 3'b000, {8'd0, 8'd0, 8'd1});
    en = 1'b0;

    // W=4: stage0 modulus 0 spans 0..15, stage1 modulus 1 passes carry through, stage2 modulus 3.
    for (int i = 0; i < 48; i++) begin
      logic       c0;
      logic       c2;
      logic [3:0] s0;
      logic [3:0] s2;
      c0 = ((i % 16) == 15);
      c2 = c0 && (((i / 16) % 3) == 2);
      s0 = 4'((i + 1) % 16);
      s2 = 4'(((i + 1) / 16) % 3);
      apply_stimulus4($sformatf("t5_c%0d", i), {c2, c0, c0}, {s2, 4'd0, s0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
